// File: rtl/regfile_wb_arbiter.sv
//------------------------------------------------------------------------------
// regfile_wb_arbiter: two per-requester writeback FIFOs drained round-robin
// into one registered regfile write port. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_wb_fifo #(
    parameter int XLEN  = 64,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [AW-1:0]              push_rd_i,
    input  logic [XLEN-1:0]            push_data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [AW-1:0]              head_rd_o,
    output logic [XLEN-1:0]            head_data_o,
    output logic [DEPTH-1:0][AW-1:0]   ent_rd_o,
    output logic [DEPTH-1:0]           ent_vld_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [PW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [DEPTH-1:0][AW-1:0]    rd_q;
    logic [DEPTH-1:0][XLEN-1:0]  data_q;
    logic [DEPTH-1:0][PW-1:0]    off_w;

    always_comb begin
        wptr_d = push_i ? wptr_q + PTR_ONE : wptr_q;
        rptr_d = pop_i  ? rptr_q + PTR_ONE : rptr_q;
        cnt_d  = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_i) begin
            rd_q[wptr_q]   <= push_rd_i;
            data_q[wptr_q] <= push_data_i;
        end
    end

    always_comb begin
        off_w     = '0;
        ent_vld_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off_w[i]     = PW'(i) - rptr_q;
            ent_vld_o[i] = ({1'b0, off_w[i]} < cnt_q);
        end
    end

    assign full_o      = (cnt_q == CNT_FULL);
    assign empty_o     = (cnt_q == '0);
    assign head_rd_o   = rd_q[rptr_q];
    assign head_data_o = data_q[rptr_q];
    assign ent_rd_o    = rd_q;
endmodule

module regfile_wb_arbiter #(
    parameter int XLEN  = 64,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [AW-1:0]       alu_rd,
    input  logic [XLEN-1:0]     alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [AW-1:0]       mem_rd,
    input  logic [XLEN-1:0]     mem_data,
    output logic                RegWrite,
    output logic [AW-1:0]       wa,
    output logic [XLEN-1:0]     wd,
    output logic [2**AW-1:0]    pending,
    output logic                grant_id
);
    localparam int NREG = 2**AW;

    logic                      alu_full_w, alu_empty_w, mem_full_w, mem_empty_w;
    logic                      alu_push_w, mem_push_w, alu_pop_w, mem_pop_w;
    logic [AW-1:0]             alu_head_rd_w, mem_head_rd_w;
    logic [XLEN-1:0]           alu_head_data_w, mem_head_data_w;
    logic [DEPTH-1:0][AW-1:0]  alu_ent_rd_w, mem_ent_rd_w;
    logic [DEPTH-1:0]          alu_ent_vld_w, mem_ent_vld_w;
    logic                      grant_w, sel_w;

    logic                      regwrite_q, regwrite_d;
    logic [AW-1:0]             wa_q, wa_d;
    logic [XLEN-1:0]           wd_q, wd_d;
    logic                      gid_q, gid_d;
    logic                      last_grant_q, last_grant_d;
    logic [NREG-1:0]           pending_w;

    assign alu_ready = !alu_full_w;
    assign mem_ready = !mem_full_w;

    // Writes to x0 complete the handshake but are dropped here.
    assign alu_push_w = alu_valid && !alu_full_w && (alu_rd != '0);
    assign mem_push_w = mem_valid && !mem_full_w && (mem_rd != '0);

    regfile_wb_fifo #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) u_alu_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (alu_push_w),
        .push_rd_i   (alu_rd),
        .push_data_i (alu_data),
        .pop_i       (alu_pop_w),
        .full_o      (alu_full_w),
        .empty_o     (alu_empty_w),
        .head_rd_o   (alu_head_rd_w),
        .head_data_o (alu_head_data_w),
        .ent_rd_o    (alu_ent_rd_w),
        .ent_vld_o   (alu_ent_vld_w)
    );

    regfile_wb_fifo #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) u_mem_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (mem_push_w),
        .push_rd_i   (mem_rd),
        .push_data_i (mem_data),
        .pop_i       (mem_pop_w),
        .full_o      (mem_full_w),
        .empty_o     (mem_empty_w),
        .head_rd_o   (mem_head_rd_w),
        .head_data_o (mem_head_data_w),
        .ent_rd_o    (mem_ent_rd_w),
        .ent_vld_o   (mem_ent_vld_w)
    );

    always_comb begin
        grant_w      = !alu_empty_w || !mem_empty_w;
        sel_w        = 1'b0;
        if (alu_empty_w)
            sel_w = 1'b1;
        else if (mem_empty_w)
            sel_w = 1'b0;
        else
            sel_w = !last_grant_q;
        alu_pop_w    = grant_w && !sel_w;
        mem_pop_w    = grant_w && sel_w;
        regwrite_d   = grant_w;
        wa_d         = wa_q;
        wd_d         = wd_q;
        gid_d        = gid_q;
        last_grant_d = last_grant_q;
        if (grant_w) begin
            wa_d         = sel_w ? mem_head_rd_w   : alu_head_rd_w;
            wd_d         = sel_w ? mem_head_data_w : alu_head_data_w;
            gid_d        = sel_w;
            last_grant_d = sel_w;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwrite_q   <= 1'b0;
            wa_q         <= '0;
            wd_q         <= '0;
            gid_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            regwrite_q   <= regwrite_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
            gid_q        <= gid_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        pending_w = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_ent_vld_w[i]) pending_w[alu_ent_rd_w[i]] = 1'b1;
            if (mem_ent_vld_w[i]) pending_w[mem_ent_rd_w[i]] = 1'b1;
        end
        if (regwrite_q) pending_w[wa_q] = 1'b1;
        pending_w[0] = 1'b0;
    end

    assign RegWrite = regwrite_q;
    assign wa       = wa_q;
    assign wd       = wd_q;
    assign grant_id = gid_q;
    assign pending  = pending_w;
endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
//------------------------------------------------------------------------------
// tb_regfile_wb_arbiter: directed stimulus with a write-port scoreboard.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_rd, mem_rd;
    logic [63:0] alu_data, mem_data;
    logic        RegWrite;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [31:0] pending;
    logic        grant_id;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
        logic        gid;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic mr_hist [0:127];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(64), .AW(5), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .RegWrite  (RegWrite),
        .wa        (wa),
        .wd        (wd),
        .pending   (pending),
        .grant_id  (grant_id)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input int rd, input logic [63:0] data, input logic gid);
        exp_t e;
        e.rd   = 5'(rd);
        e.data = data;
        e.gid  = gid;
        q.push_back(e);
    endtask

    // Scoreboard monitor: every presented write must match the queue head.
    always @(negedge clk) begin
        if (reset === 1'b1 && RegWrite === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got wa=%0d wd=%0h expected no write", wa, wd);
            end else begin
                mon_e = q.pop_front();
                chk("write_wa", 64'(wa), 64'(mon_e.rd));
                chk("write_wd", wd, mon_e.data);
                chk("write_gid", 64'(grant_id), 64'(mon_e.gid));
            end
        end
    end

    task automatic run_stream(input int na, input int a_rd0, input int nm, input int m_rd0,
                              input logic [63:0] a_base, input logic [63:0] m_base);
        int   ai = 0;
        int   mi = 0;
        int   it = 0;
        logic acca, accm;
        while ((ai < na || mi < nm) && it < 100) begin
            alu_valid = (ai < na);
            alu_rd    = 5'(a_rd0 + ai);
            alu_data  = a_base + 64'(ai);
            mem_valid = (mi < nm);
            mem_rd    = 5'(m_rd0 + mi);
            mem_data  = m_base + 64'(mi);
            @(negedge clk);
            acca = alu_valid && alu_ready;
            accm = mem_valid && mem_ready;
            mr_hist[it] = mem_ready;
            tick();
            if (acca) ai++;
            if (accm) mi++;
            it++;
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("stream_accepted_all", 64'(ai + mi), 64'(na + nm));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) tick();
        chk("queue_drained", 64'(q.size()), 64'd0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
        tick();
        tick();
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_ready", 64'({alu_ready, mem_ready}), 64'd3);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Reset asserted mid-stream with entries queued in both FIFOs
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 64'h99;
        tick();
        alu_rd = 5'd2; alu_data = 64'h22;
        mem_rd = 5'd10; mem_data = 64'hAA;
        tick();
        chk("t1_pending_before", 64'(pending), 64'h606);
        chk("t1_mem_full", 64'(mem_ready), 64'd0);
        chk("t1_wa_before", 64'(wa), 64'd1);
        reset = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        chk("t1_rst_regwrite", 64'(RegWrite), 64'd0);
        chk("t1_rst_wa", 64'(wa), 64'd0);
        chk("t1_rst_wd", wd, 64'd0);
        chk("t1_rst_pending", 64'(pending), 64'd0);
        chk("t1_rst_ready", 64'({alu_ready, mem_ready}), 64'd3);
        chk("t1_rst_gid", 64'(grant_id), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_no_stale_write", 64'(RegWrite), 64'd0);
        end

        // Both ports saturated: strict alternation starting with ALU
        for (int k = 0; k < 8; k++) begin
            expect_wr(1 + k, 64'h100 + 64'(k), 1'b0);
            expect_wr(9 + k, 64'h200 + 64'(k), 1'b1);
        end
        fork
            run_stream(8, 1, 8, 9, 64'h100, 64'h200);
            begin
                bit found = 1'b0;
                for (int i = 0; i < 10 && !found; i++) begin
                    tick();
                    if (RegWrite) found = 1'b1;
                end
                chk("t3_first_write", 64'(found), 64'd1);
                for (int i = 0; i < 15; i++) begin
                    tick();
                    chk("t3_continuous", 64'(RegWrite), 64'd1);
                end
                tick();
                chk("t3_idle_after", 64'(RegWrite), 64'd0);
            end
        join
        wait_drain();

        // Mem backpressure against a saturated ALU stream
        expect_wr(1, 64'h300, 1'b0); expect_wr(20, 64'h400, 1'b1);
        expect_wr(2, 64'h301, 1'b0); expect_wr(21, 64'h401, 1'b1);
        expect_wr(3, 64'h302, 1'b0); expect_wr(22, 64'h402, 1'b1);
        expect_wr(4, 64'h303, 1'b0); expect_wr(5, 64'h304, 1'b0);
        expect_wr(6, 64'h305, 1'b0);
        run_stream(6, 1, 3, 20, 64'h300, 64'h400);
        chk("t4_mem_ready_0", 64'(mr_hist[0]), 64'd1);
        chk("t4_mem_ready_1", 64'(mr_hist[1]), 64'd1);
        chk("t4_mem_ready_2", 64'(mr_hist[2]), 64'd0);
        chk("t4_mem_ready_3", 64'(mr_hist[3]), 64'd1);
        wait_drain();

        // Single ALU write latency and pending window
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1;
        expect_wr(5, 64'h1, 1'b0);
        tick();
        alu_valid = 1'b0;
        chk("t2_pending_queued", 64'(pending), 64'h20);
        chk("t2_no_write_yet", 64'(RegWrite), 64'd0);
        tick();
        chk("t2_regwrite", 64'(RegWrite), 64'd1);
        chk("t2_pending_present", 64'(pending), 64'h20);
        chk("t2_gid", 64'(grant_id), 64'd0);
        tick();
        chk("t2_pending_clear", 64'(pending), 64'd0);
        chk("t2_regwrite_low", 64'(RegWrite), 64'd0);

        // Idle after a write holds wa/wd
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h2A;
        expect_wr(7, 64'h2A, 1'b0);
        tick();
        alu_valid = 1'b0;
        tick();
        tick();
        chk("t6_regwrite_low", 64'(RegWrite), 64'd0);
        chk("t6_wa_hold", 64'(wa), 64'd7);
        chk("t6_wd_hold", wd, 64'h2A);

        // x0 write is accepted then discarded
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEAD;
        chk("t5_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_pending", 64'(pending), 64'd0);
            tick();
            chk("t5_no_write", 64'(RegWrite), 64'd0);
        end
        chk("t5_wa_unchanged", 64'(wa), 64'd7);
        chk("t5_wd_unchanged", wd, 64'h2A);

        wait_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
